// File: rtl/rr_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// rr_arbiter_ctrl
//
// Round-robin arbiter controller for N requesters sharing one resource.
// A three-state FSM (IDLE / GRANT / RELEASE) hands out a registered one-hot
// grant. The winner is the first requesting index found when scanning from
// the search pointer upward with wrap-around. After each grant the pointer
// moves just past the winner, so a released owner that keeps requesting
// queues behind every other requester. Each release is followed by exactly
// one all-zero cycle before the next grant.
//
// Parameters
//   N    number of requesters (power of two, >= 2)
//   TMO  maximum grant hold in cycles (only meaningful with ARB_TIMEOUT_EN)
//
// Ports
//   clk        in   block clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[N]     in   level request per requester
//   done       in   release pulse from the current owner (ignored unless GRANT)
//   gnt[N]     out  registered one-hot grant, zero when there is no owner
//   gnt_idx[k] out  binary index of the granted requester, zero when idle
//   gnt_valid  out  high while gnt is non-zero
//   tmo_flag   out  one-cycle pulse in the RELEASE cycle after a forced release
//
// Build macros
//   ARB_TIMEOUT_EN  adds a hold counter that forces a release after TMO
//                   grant cycles; otherwise grants last until released and
//                   tmo_flag is tied low.
//   USE_POWER_PINS  exposes vccd1/vssd1 inout supply pins.
// -----------------------------------------------------------------------------
module rr_arbiter_ctrl #(
    parameter int N   = 64,
    parameter int TMO = 256
) (
`ifdef USE_POWER_PINS
    inout  wire                   vccd1,
    inout  wire                   vssd1,
`endif
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic                  done,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  gnt_valid,
    output logic                  tmo_flag
);

    localparam int K = $clog2(N);

    localparam logic [K-1:0] IDX_ONE  = K'(1'b1);
    localparam logic [K-1:0] IDX_ZERO = {K{1'b0}};
    localparam logic [N-1:0] VEC_ZERO = {N{1'b0}};

    // Pointer wrap relies on N being a power of two; a non-positive hold
    // limit has no meaning in any build.
    if ((N < 32'sd2) || ((N & (N - 32'sd1)) != 32'sd0) || (TMO < 32'sd1)) begin : g_bad_cfg
        $error("rr_arbiter_ctrl: N must be a power of two >= 2 and TMO must be positive");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Round-robin pick: returns {found, index} of the first set request bit
    // scanning ptr_v, ptr_v+1, ... with natural k-bit wrap-around.
    // -------------------------------------------------------------------------
    function automatic logic [K:0] rr_pick(input logic [N-1:0] req_v,
                                           input logic [K-1:0] ptr_v);
        logic [K-1:0] cand;
        logic [K-1:0] win;
        logic         found;
        logic         hit;
        cand  = ptr_v;
        win   = IDX_ZERO;
        found = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Only the first hit in scan order may update the winner.
            hit   = req_v[cand] & ~found;
            win   = hit ? cand : win;
            found = found | hit;
            cand  = cand + IDX_ONE;
        end
        return {found, win};
    endfunction

    state_e        state_q, state_d;
    logic [K-1:0]  ptr_q,   ptr_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [K-1:0]  idx_q,   idx_d;
    logic          valid_q, valid_d;
    logic          tmo_q,   tmo_d;

    logic [K:0]    pick_s;
    logic          pick_found_s;
    logic [K-1:0]  pick_idx_s;
    logic          release_s;

`ifdef ARB_TIMEOUT_EN
    // With TMO below 2 the counter still exists but never forces a release.
    localparam bit           TMO_ON   = (TMO >= 32'sd2);
    localparam int           CW       = (TMO >= 32'sd2) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_expired_s;
`endif

    // Next-state, pointer and next-output computation for the arbiter FSM.
    always_comb begin
        pick_s       = rr_pick(req, ptr_q);
        pick_found_s = pick_s[K];
        pick_idx_s   = pick_s[K-1:0];
        // idx_q holds the owner while in GRANT, so this is the owner's request.
        release_s    = done | ~req[idx_q];

        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        hold_expired_s = TMO_ON && (cnt_q == CNT_LAST);
`endif

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (pick_found_s) begin
                    state_d            = ST_GRANT;
                    gnt_d              = VEC_ZERO;
                    gnt_d[pick_idx_s]  = 1'b1;
                    idx_d              = pick_idx_s;
                    valid_d            = 1'b1;
                    ptr_d              = pick_idx_s + IDX_ONE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d              = CNT_ZERO;
`endif
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = VEC_ZERO;
                    idx_d   = IDX_ZERO;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    // done and a dropped request together are still one release.
                    state_d = ST_RELEASE;
                    gnt_d   = VEC_ZERO;
                    idx_d   = IDX_ZERO;
                    valid_d = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_expired_s) begin
                    state_d = ST_RELEASE;
                    gnt_d   = VEC_ZERO;
                    idx_d   = IDX_ZERO;
                    valid_d = 1'b0;
                    tmo_d   = 1'b1;
                end
`endif
                else begin
                    // Non-owner request changes are ignored while holding.
                    state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_ONE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = VEC_ZERO;
                idx_d   = IDX_ZERO;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state, search pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_ZERO;
            gnt_q   <= VEC_ZERO;
            idx_q   <= IDX_ZERO;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant hold counter: cleared on entry to GRANT, counts each held cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign tmo_flag  = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for rr_arbiter_ctrl (N=8, TMO=4).
// The driver applies stimulus on the falling edge, advances a behavioural
// model of the round-robin rules and pushes the expected registered outputs
// into a queue; a monitor pops and compares after every rising edge and also
// checks the order of grants as they appear.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_ctrl;

    localparam int N   = 8;
    localparam int K   = 3;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [K-1:0] gnt_idx;
    logic         gnt_valid;
    logic         tmo_flag;
`ifdef USE_POWER_PINS
    wire          vccd1;
    wire          vssd1;
`endif

    always #5 clk = ~clk;

    rr_arbiter_ctrl #(.N(N), .TMO(TMO)) dut (
`ifdef USE_POWER_PINS
        .vccd1     (vccd1),
        .vssd1     (vssd1),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo_flag  (tmo_flag)
    );

    typedef struct {
        logic [N-1:0] gnt;
        int           idx;
        bit           valid;
        bit           tmo;
    } exp_t;

    exp_t exp_q[$];
    int   order_q[$];

    int nchecks = 0;
    int nfail   = 0;

    // Reference model: current owner (-1 = none), search pointer, hold length.
    int m_owner;
    int m_ptr;
    int m_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endfunction

    // One clock edge worth of arbitration rules, then queue the outputs the
    // DUT must show after that edge.
    function automatic void model_step(input logic [N-1:0] r, input logic d);
        exp_t         e;
        bit           tmo_v;
        bit           found;
        int           cand;
        logic [N-1:0] one_v;
        tmo_v = 1'b0;
        one_v = 1;
        if (m_owner >= 0) begin
            if (d || !r[m_owner]) begin
                m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_hold >= TMO) begin
                m_owner = -1;
                tmo_v   = 1'b1;
            end
`endif
            else begin
                m_hold++;
            end
        end else if (r != 0) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                cand = (m_ptr + j) % N;
                if (!found && r[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                end
            end
            m_ptr  = (m_owner + 1) % N;
            m_hold = 1;
            order_q.push_back(m_owner);
        end
        e.gnt   = (m_owner >= 0) ? (one_v << m_owner) : '0;
        e.idx   = (m_owner >= 0) ? m_owner : 0;
        e.valid = (m_owner >= 0);
        e.tmo   = tmo_v;
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        done  = d;
        model_step(r, d);
    endtask

    // Monitor: compare every queued expectation and the grant order.
    initial begin : monitor
        exp_t e;
        bit   prev_valid;
        int   want;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt",       32'(gnt),       32'(e.gnt));
                check("gnt_idx",   32'(gnt_idx),   32'(e.idx));
                check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
                check("tmo_flag",  32'(tmo_flag),  32'(e.tmo));
            end
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (gnt_valid && !prev_valid) begin
                if (order_q.size() == 0) begin
                    check("grant_order_unexpected", 32'(gnt_idx), 32'hFFFF_FFFF);
                end else begin
                    want = order_q.pop_front();
                    check("grant_order", 32'(gnt_idx), 32'(want));
                end
            end
            prev_valid = gnt_valid;
        end
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        logic [N-1:0] r;
        int           o;
        int           tries;

        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt",       32'(gnt),       32'd0);
        check("reset_gnt_idx",   32'(gnt_idx),   32'd0);
        check("reset_gnt_valid", 32'(gnt_valid), 32'd0);
        check("reset_tmo_flag",  32'(tmo_flag),  32'd0);

        // All requesting, owner pulses done each grant: 0,1,...,7,0.
        for (int i = 0; i < 18; i++) drive(8'hFF, m_owner >= 0);

        // Park the pointer at 7, then check wrap from 7 to 0.
        drive(8'h40, 1'b0);
        drive(8'h40, 1'b1);
        drive(8'h81, 1'b0);
        drive(8'h81, 1'b1);
        drive(8'h81, 1'b0);
        drive(8'h81, 1'b1);

        // Owner drops its request and pulses done in the same cycle.
        drive(8'hFF, 1'b0);
        o = m_owner;
        r = 8'hFF;
        r[o] = 1'b0;
        drive(r, 1'b1);
        drive(8'hFF, 1'b0);
        // Non-owners toggle while the owner keeps requesting.
        o = m_owner;
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            r[o] = 1'b1;
            drive(r, 1'b0);
        end
        drive(8'hFF, 1'b1);

        // Single requester holding with no done.
        for (int i = 0; i < 12; i++) drive(8'h04, 1'b0);
        drive(8'h04, 1'b1);
        drive(8'h00, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom) & 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            drive(r, $urandom_range(0, 3) == 0);
        end

        // Reset asserted between edges while a grant is held.
        tries = 0;
        drive(8'hFF, 1'b0);
        while (m_owner < 0 && tries < 20) begin
            drive(8'hFF, 1'b0);
            tries++;
        end
        @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(gnt_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_gnt",       32'(gnt),       32'd0);
        check("async_reset_gnt_valid", 32'(gnt_valid), 32'd0);
        check("async_reset_gnt_idx",   32'(gnt_idx),   32'd0);
        check("async_reset_tmo_flag",  32'(tmo_flag),  32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        drive(8'hFF, 1'b0);
        drive(8'hFF, 1'b1);
        drive(8'hFF, 1'b0);
        drive(8'hFF, 1'b1);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);

        @(posedge clk);
        #2;
        check("exp_queue_drained",   32'(exp_q.size()),   32'd0);
        check("order_queue_drained", 32'(order_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
